regfile_writeback_queue: RTL and testbench

//  Write side of the 32x32 register file. Buffers results from multi-cycle units
//  (load, mult/div) in a small FIFO and retires at most one per cycle onto the single

---
 rtl/regfile_pkg.sv | 11 +
 rtl/wb_bypass_match.sv | 48 ++++
 rtl/regfile_writeback_queue.sv | 118 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and widths, used by the writeback queue, the register file and decode.
package regfile_pkg;
   localparam int        REG_ADDR_W = 5;
   localparam int        REG_DATA_W = 32;
   localparam logic [4:0] REG_ZERO  = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wreg;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the queued writes plus the write currently on the port.
// Purely combinational; index 0 never hits.
module wb_bypass_match
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [ADDR_W-1:0]          i_addr,
   input  logic [ADDR_W-1:0]          i_reg_q [DEPTH],
   input  logic [DATA_W-1:0]          i_dat_q [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   i_head,
   input  logic [$clog2(DEPTH):0]     i_count,
   input  logic                       i_out_vld,
   input  logic [ADDR_W-1:0]          i_out_reg,
   input  logic [DATA_W-1:0]          i_out_dat,
   output logic                       o_hit,
   output logic [DATA_W-1:0]          o_dat
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] w_idx;

   // The port write is older than every queued entry, so it is checked first and
   // each later (younger) queued match overrides it.
   always_comb begin
      o_hit = 1'b0;
      o_dat = '0;
      w_idx = '0;
      if (i_out_vld && (i_out_reg == i_addr)) begin
         o_hit = 1'b1;
         o_dat = i_out_dat;
      end
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = i_head + PW'(i);
         if ((CW'(i) < i_count) && (i_reg_q[w_idx] == i_addr)) begin
            o_hit = 1'b1;
            o_dat = i_dat_q[w_idx];
         end
      end
      if (i_addr == ADDR_W'(REG_ZERO)) begin
         o_hit = 1'b0;
         o_dat = '0;
      end
   end
endmodule

// File: rtl/regfile_writeback_queue.sv
// FIFO between multi-cycle units and the single register-file write port; WB_BYPASS_EN adds decode forwarding.
// Push-to-write latency 1 cycle; in_ready=!full (no same-cycle pop credit); wr_stall holds the head.
module regfile_writeback_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_reg,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       flush,
   input  logic                       wr_stall,
   output logic                       regWrite,
   output logic [ADDR_W-1:0]          writeRegister,
   output logic [DATA_W-1:0]          writeData,
   output logic [$clog2(DEPTH):0]     count
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]          register1,
   input  logic [ADDR_W-1:0]          register2,
   output logic                       hit1,
   output logic                       hit2,
   output logic [DATA_W-1:0]          fwdData1,
   output logic [DATA_W-1:0]          fwdData2
`endif
);
   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = PW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] r_reg_q [DEPTH];
   logic [DATA_W-1:0] r_dat_q [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_reg;
   logic [DATA_W-1:0] r_wr_dat;
   logic              w_push;
   logic              w_pop;

   assign in_ready = (r_count != FULL);
   // Writes to $zero are handshaken normally but never occupy an entry.
   assign w_push   = in_valid & in_ready & ~flush & (in_reg != ADDR_W'(REG_ZERO));
   assign w_pop    = (r_count != '0) & ~wr_stall & ~flush;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_reg_q[r_tail] <= in_reg;
         r_dat_q[r_tail] <= in_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_wr_en  <= 1'b0;
         r_wr_reg <= '0;
         r_wr_dat <= '0;
      end else if (flush) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_wr_en  <= 1'b0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head   <= r_head + 1'b1;
            r_wr_reg <= r_reg_q[r_head];
            r_wr_dat <= r_dat_q[r_head];
         end
         r_wr_en <= w_pop;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign regWrite      = r_wr_en;
   assign writeRegister = r_wr_reg;
   assign writeData     = r_wr_dat;
   assign count         = r_count;

`ifdef WB_BYPASS_EN
   wb_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match1 (
      .i_addr    (register1),
      .i_reg_q   (r_reg_q),
      .i_dat_q   (r_dat_q),
      .i_head    (r_head),
      .i_count   (r_count),
      .i_out_vld (r_wr_en),
      .i_out_reg (r_wr_reg),
      .i_out_dat (r_wr_dat),
      .o_hit     (hit1),
      .o_dat     (fwdData1)
   );

   wb_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match2 (
      .i_addr    (register2),
      .i_reg_q   (r_reg_q),
      .i_dat_q   (r_dat_q),
      .i_head    (r_head),
      .i_count   (r_count),
      .i_out_vld (r_wr_en),
      .i_out_reg (r_wr_reg),
      .i_out_dat (r_wr_dat),
      .o_hit     (hit2),
      .o_dat     (fwdData2)
   );
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed vector table plus hand-written sequences for the writeback queue.
module tb_regfile_writeback_queue;
   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_reg;
   logic [31:0] in_data;
   logic        flush;
   logic        wr_stall;
   logic        regWrite;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic [2:0]  count;
`ifdef WB_BYPASS_EN
   logic [4:0]  register1;
   logic [4:0]  register2;
   logic        hit1;
   logic        hit2;
   logic [31:0] fwdData1;
   logic [31:0] fwdData2;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   regfile_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_reg        (in_reg),
      .in_data       (in_data),
      .flush         (flush),
      .wr_stall      (wr_stall),
      .regWrite      (regWrite),
      .writeRegister (writeRegister),
      .writeData     (writeData),
      .count         (count)
`ifdef WB_BYPASS_EN
      ,
      .register1     (register1),
      .register2     (register2),
      .hit1          (hit1),
      .hit2          (hit2),
      .fwdData1      (fwdData1),
      .fwdData2      (fwdData2)
`endif
   );

   typedef struct {
      logic        vld;
      logic [4:0]  rg;
      logic [31:0] dat;
      logic        fl;
      logic        st;
      logic        e_wr;
      logic [4:0]  e_reg;
      logic [31:0] e_dat;
      logic [2:0]  e_cnt;
      logic        e_rdy;
   } vec_t;

   localparam int NV = 21;
   vec_t vt [NV];

   function automatic vec_t mk(logic vld, logic [4:0] rg, logic [31:0] dat, logic fl, logic st,
                               logic e_wr, logic [4:0] e_reg, logic [31:0] e_dat,
                               logic [2:0] e_cnt, logic e_rdy);
      vec_t v;
      v.vld = vld; v.rg = rg; v.dat = dat; v.fl = fl; v.st = st;
      v.e_wr = e_wr; v.e_reg = e_reg; v.e_dat = e_dat; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [4:0] rg, input logic [31:0] dat,
                        input logic fl, input logic st);
      in_valid = vld; in_reg = rg; in_data = dat; flush = fl; wr_stall = st;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [4:0]  sb_reg [$];
   logic [31:0] sb_dat [$];

   initial begin
      // test 1: single write
      vt[0]  = mk(1, 5'd3,  32'hDEAD_BEEF, 0, 0,  0, 5'd0,  32'h0,         3'd1, 1);
      vt[1]  = mk(0, 5'd0,  32'h0,         0, 0,  1, 5'd3,  32'hDEAD_BEEF, 3'd0, 1);
      vt[2]  = mk(0, 5'd0,  32'h0,         0, 0,  0, 5'd0,  32'h0,         3'd0, 1);
      // test 2: fill under stall, refuse fifth, drain in order
      vt[3]  = mk(1, 5'd1,  32'h11,        0, 1,  0, 5'd0,  32'h0,         3'd1, 1);
      vt[4]  = mk(1, 5'd2,  32'h22,        0, 1,  0, 5'd0,  32'h0,         3'd2, 1);
      vt[5]  = mk(1, 5'd4,  32'h44,        0, 1,  0, 5'd0,  32'h0,         3'd3, 1);
      vt[6]  = mk(1, 5'd5,  32'h55,        0, 1,  0, 5'd0,  32'h0,         3'd4, 0);
      vt[7]  = mk(1, 5'd6,  32'h66,        0, 1,  0, 5'd0,  32'h0,         3'd4, 0);
      vt[8]  = mk(0, 5'd0,  32'h0,         0, 0,  1, 5'd1,  32'h11,        3'd3, 1);
      vt[9]  = mk(0, 5'd0,  32'h0,         0, 0,  1, 5'd2,  32'h22,        3'd2, 1);
      vt[10] = mk(0, 5'd0,  32'h0,         0, 0,  1, 5'd4,  32'h44,        3'd1, 1);
      vt[11] = mk(0, 5'd0,  32'h0,         0, 0,  1, 5'd5,  32'h55,        3'd0, 1);
      vt[12] = mk(0, 5'd0,  32'h0,         0, 0,  0, 5'd0,  32'h0,         3'd0, 1);
      // test 3: $zero write dropped
      vt[13] = mk(1, 5'd0,  32'h5,         0, 0,  0, 5'd0,  32'h0,         3'd0, 1);
      vt[14] = mk(0, 5'd0,  32'h0,         0, 0,  0, 5'd0,  32'h0,         3'd0, 1);
      // test 4: flush with a push in the same cycle
      vt[15] = mk(1, 5'd8,  32'h80,        0, 1,  0, 5'd0,  32'h0,         3'd1, 1);
      vt[16] = mk(1, 5'd9,  32'h90,        0, 1,  0, 5'd0,  32'h0,         3'd2, 1);
      vt[17] = mk(1, 5'd10, 32'hA0,        0, 1,  0, 5'd0,  32'h0,         3'd3, 1);
      vt[18] = mk(1, 5'd11, 32'hB0,        1, 0,  0, 5'd0,  32'h0,         3'd0, 1);
      vt[19] = mk(0, 5'd0,  32'h0,         0, 0,  0, 5'd0,  32'h0,         3'd0, 1);
      vt[20] = mk(0, 5'd0,  32'h0,         0, 0,  0, 5'd0,  32'h0,         3'd0, 1);

`ifdef WB_BYPASS_EN
      register1 = 5'd0;
      register2 = 5'd0;
`endif
      drive(0, 5'd0, 32'h0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("reset.count",    32'(count), 32'd0);
      chk("reset.regWrite", 32'(regWrite), 32'd0);
      chk("reset.wreg",     32'(writeRegister), 32'd0);
      chk("reset.wdata",    writeData, 32'd0);
      chk("reset.in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].vld, vt[i].rg, vt[i].dat, vt[i].fl, vt[i].st);
         tick();
         chk($sformatf("v%0d.regWrite", i), 32'(regWrite), 32'(vt[i].e_wr));
         chk($sformatf("v%0d.count", i),    32'(count),    32'(vt[i].e_cnt));
         chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
         if (vt[i].e_wr) begin
            chk($sformatf("v%0d.wreg", i),  32'(writeRegister), 32'(vt[i].e_reg));
            chk($sformatf("v%0d.wdata", i), writeData,          vt[i].e_dat);
         end
      end
      drive(0, 5'd0, 32'h0, 0, 0);

      // test 6: two entries in flight, push+pop every cycle across pointer wrap
      for (int i = 0; i < 2; i++) begin
         drive(1, 5'(i + 1), 32'h1000 + 32'(i), 0, 1);
         tick();
         sb_reg.push_back(5'(i + 1));
         sb_dat.push_back(32'h1000 + 32'(i));
      end
      chk("wrap.prime_count", 32'(count), 32'd2);
      for (int i = 2; i < 22; i++) begin
         drive(1, 5'((i % 30) + 1), 32'h1000 + 32'(i), 0, 0);
         tick();
         sb_reg.push_back(5'((i % 30) + 1));
         sb_dat.push_back(32'h1000 + 32'(i));
         chk($sformatf("wrap%0d.count", i),    32'(count),    32'd2);
         chk($sformatf("wrap%0d.regWrite", i), 32'(regWrite), 32'd1);
         chk($sformatf("wrap%0d.wreg", i),     32'(writeRegister), 32'(sb_reg.pop_front()));
         chk($sformatf("wrap%0d.wdata", i),    writeData,          sb_dat.pop_front());
      end
      drive(0, 5'd0, 32'h0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("drain%0d.regWrite", i), 32'(regWrite), 32'd1);
         chk($sformatf("drain%0d.wdata", i),    writeData,     sb_dat.pop_front());
         void'(sb_reg.pop_front());
      end
      tick();
      chk("drain.count",    32'(count),    32'd0);
      chk("drain.regWrite", 32'(regWrite), 32'd0);

`ifdef WB_BYPASS_EN
      // test 5: youngest queued match forwards; register 0 never hits
      drive(1, 5'd7, 32'd1, 0, 1);
      tick();
      drive(1, 5'd7, 32'd2, 0, 1);
      tick();
      drive(0, 5'd0, 32'h0, 0, 1);
      register1 = 5'd7;
      register2 = 5'd0;
      #1;
      chk("byp.hit1", 32'(hit1),   32'd1);
      chk("byp.fwd1", fwdData1,    32'd2);
      chk("byp.hit2", 32'(hit2),   32'd0);
      drive(0, 5'd0, 32'h0, 0, 0);
      tick();
      tick();
      tick();
      register1 = 5'd0;
`endif

      // reset mid-operation drops queued entries
      drive(1, 5'd12, 32'hC0, 0, 1);
      tick();
      drive(0, 5'd0, 32'h0, 0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(0, 5'd0, 32'h0, 0, 0);
      chk("rst_mid.count",    32'(count),    32'd0);
      chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("rst_mid.regWrite", 32'(regWrite), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
